// File: rtl/serial_frame_deserializer.sv
// Start-bit framed serial receiver: LSB-first data, optional even parity, stop-bit check.
// Presents the received word with a one-cycle valid pulse and sticky-until-next-frame error flags.
//
// state     | meaning
// IDLE      | line idle, waiting for a start bit (din=0)
// DATA      | shifting in DATA_W data bits
// PARITY    | sampling the even-parity bit
// STOP      | sampling the stop bit, publishing the frame
// WAIT_HIGH | stop bit was low; waiting for the line to return high
module serial_frame_deserializer #(
    parameter int DATA_W    = 8,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    input  logic              en,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d, shift_in;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              par_q, par_d;
    logic              perr_pend_q, perr_pend_d;
    logic              valid_q, valid_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;

    // New bits enter at the MSB so the first received bit ends up in bit 0.
    generate
        if (DATA_W == 1) begin : g_shift_one
            assign shift_in = din;
        end else begin : g_shift_many
            assign shift_in = {din, shift_q[DATA_W-1:1]};
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        par_d       = par_q;
        perr_pend_d = perr_pend_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        perr_d      = perr_q;
        ferr_d      = ferr_q;

        if (en) begin
            case (state_q)
                IDLE: begin
                    if (!din) begin
                        state_d     = DATA;
                        cnt_d       = '0;
                        par_d       = 1'b0;
                        perr_pend_d = 1'b0;
                    end
                end
                DATA: begin
                    shift_d = shift_in;
                    par_d   = par_q ^ din;
                    if (cnt_q == LAST_CNT) begin
                        state_d = PARITY_EN ? PARITY : STOP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PARITY: begin
                    perr_pend_d = par_q ^ din;
                    state_d     = STOP;
                end
                STOP: begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                    perr_d  = PARITY_EN ? perr_pend_q : 1'b0;
                    ferr_d  = ~din;
                    state_d = din ? IDLE : WAIT_HIGH;
                end
                WAIT_HIGH: begin
                    if (din) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            par_q       <= 1'b0;
            perr_pend_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            par_q       <= par_d;
            perr_pend_q <= perr_pend_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
        end
    end

    assign data_out   = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Directed bench for serial_frame_deserializer (DATA_W=8, even parity enabled).
// Inputs change 1 ns after each rising edge; outputs are sampled at that same point.
module tb_serial_frame_deserializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       en;
    logic [7:0] data_out;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int n_chk  = 0;
    int n_pass = 0;
    int edge_cnt = 0;
    int vcnt = 0;
    int v_when_dis = 0;
    int start_edge = 0;
    int e1 = 0;

    serial_frame_deserializer #(.DATA_W(8), .PARITY_EN(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .en         (en),
        .data_out   (data_out),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic b, input logic e);
        din = b;
        en  = e;
        @(posedge clk);
        #1;
        edge_cnt++;
        if (valid === 1'b1) begin
            vcnt++;
            if (!e) v_when_dis++;
        end
    endtask

    // Start bit, 8 data bits LSB first, parity bit, stop bit.
    // With alt=1 every non-stop bit is followed by one disabled edge holding the same value.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit,
                              input bit alt);
        vcnt = 0;
        drive(1'b0, 1'b1);
        start_edge = edge_cnt;
        if (alt) drive(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive(d[i], 1'b1);
            if (alt) drive(d[i], 1'b0);
        end
        drive(pbit, 1'b1);
        if (alt) drive(pbit, 1'b0);
        drive(sbit, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        din = 1'b1;
        en  = 1'b1;
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        rst = 1'b0;
        chk("rst_data", 32'(data_out), 32'h00);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_perr", 32'(parity_err), 0);
        chk("rst_ferr", 32'(frame_err), 0);

        // 1: 0xA5, good parity, good stop
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        chk("t1_valid", 32'(valid), 1);
        chk("t1_data", 32'(data_out), 32'hA5);
        chk("t1_perr", 32'(parity_err), 0);
        chk("t1_ferr", 32'(frame_err), 0);
        chk("t1_vcnt", 32'(vcnt), 1);
        chk("t1_edges", 32'(edge_cnt - start_edge + 1), 11);
        drive(1'b1, 1'b1);
        chk("t1_valid_drop", 32'(valid), 0);
        chk("t1_busy_idle", 32'(busy), 0);
        chk("t1_data_hold", 32'(data_out), 32'hA5);

        // 2: 0x3C with wrong parity, then with correct parity
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
        chk("t2_valid", 32'(valid), 1);
        chk("t2_data", 32'(data_out), 32'h3C);
        chk("t2_perr", 32'(parity_err), 1);
        chk("t2_ferr", 32'(frame_err), 0);
        drive(1'b1, 1'b1);
        chk("t2_perr_hold", 32'(parity_err), 1);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        chk("t2b_valid", 32'(valid), 1);
        chk("t2b_perr", 32'(parity_err), 0);
        drive(1'b1, 1'b1);

        // 3: 0x0F with stop bit 0, line held low, then 0x11
        send_frame(8'h0F, 1'b0, 1'b0, 1'b0);
        chk("t3_valid", 32'(valid), 1);
        chk("t3_data", 32'(data_out), 32'h0F);
        chk("t3_ferr", 32'(frame_err), 1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1);
            chk("t3_low_valid", 32'(valid), 0);
            chk("t3_low_busy", 32'(busy), 1);
        end
        drive(1'b1, 1'b1);
        chk("t3_release_busy", 32'(busy), 0);
        chk("t3_ferr_hold", 32'(frame_err), 1);
        send_frame(8'h11, 1'b0, 1'b1, 1'b0);
        chk("t3b_valid", 32'(valid), 1);
        chk("t3b_data", 32'(data_out), 32'h11);
        chk("t3b_ferr", 32'(frame_err), 0);
        chk("t3b_perr", 32'(parity_err), 0);
        drive(1'b1, 1'b1);

        // 4: 0x81 with en on alternate edges
        v_when_dis = 0;
        send_frame(8'h81, 1'b0, 1'b1, 1'b1);
        chk("t4_valid", 32'(valid), 1);
        chk("t4_data", 32'(data_out), 32'h81);
        chk("t4_perr", 32'(parity_err), 0);
        drive(1'b1, 1'b0);
        chk("t4_valid_dis", 32'(valid), 0);
        chk("t4_data_hold", 32'(data_out), 32'h81);
        drive(1'b1, 1'b1);
        chk("t4_valid_en0", 32'(v_when_dis), 0);
        chk("t4_vcnt", 32'(vcnt), 1);

        // 5: reset after 4 data bits of 0xFF, then 0x5A
        drive(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1);
        chk("t5_busy_mid", 32'(busy), 1);
        rst = 1'b1;
        drive(1'b1, 1'b1);
        rst = 1'b0;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_data", 32'(data_out), 32'h00);
        chk("t5_valid", 32'(valid), 0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        chk("t5b_valid", 32'(valid), 1);
        chk("t5b_data", 32'(data_out), 32'h5A);
        chk("t5b_perr", 32'(parity_err), 0);
        chk("t5b_ferr", 32'(frame_err), 0);
        drive(1'b1, 1'b1);

        // 6: 0x12 then 0x34 back to back
        send_frame(8'h12, 1'b0, 1'b1, 1'b0);
        chk("t6a_valid", 32'(valid), 1);
        chk("t6a_data", 32'(data_out), 32'h12);
        e1 = edge_cnt;
        send_frame(8'h34, 1'b1, 1'b1, 1'b0);
        chk("t6b_valid", 32'(valid), 1);
        chk("t6b_data", 32'(data_out), 32'h34);
        chk("t6b_perr", 32'(parity_err), 0);
        chk("t6b_vcnt", 32'(vcnt), 1);
        chk("t6_spacing", 32'(edge_cnt - e1), 11);
        drive(1'b1, 1'b1);
        chk("t6_busy_idle", 32'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
